// File: rtl/dsp48e2.sv
// dsp48e2: behavioural DSP48E2-style slice with a 27x18 signed multiplier,
// W/X/Y/Z operand muxes and a 48-bit ALU that can split into SIMD lanes.
module dsp48e2 #(
  parameter string USE_SIMD = "ONE48",
  parameter string USE_MULT = "MULTIPLY",
  parameter int    AREG     = 1,
  parameter int    BREG     = 1,
  parameter int    CREG     = 1,
  parameter int    PREG     = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [29:0] a,
  input  logic [17:0] b,
  input  logic [47:0] c,
  input  logic        carryin,
  input  logic [3:0]  alumode,
  input  logic [8:0]  opmode,
  input  logic        cea,
  input  logic        ceb,
  input  logic        cec,
  input  logic        cep,
  output logic [47:0] p,
  output logic [3:0]  carryout
);
  localparam int NL = (USE_SIMD == "FOUR12") ? 4 : (USE_SIMD == "TWO24") ? 2 : 1;
  localparam int LW = 48 / NL;
  localparam bit MUL_ON = (USE_MULT == "MULTIPLY") && (USE_SIMD == "ONE48");
  logic [29:0] w_a;
  logic [17:0] w_b;
  logic [47:0] w_c, w_ab, w_m, w_pfb, w_x, w_y, w_z, w_w, w_ar, w_lg, w_alu;
  logic signed [47:0] w_ma, w_mb;
  logic [NL-1:0] w_lc;
  logic [3:0] w_co;
  logic w_arith, w_y2;
  if (AREG != 0) begin : g_areg
    logic [29:0] r_a;
    always_ff @(posedge clock or negedge reset)
      if (!reset) r_a <= '0;
      else if (cea) r_a <= a;
    assign w_a = r_a;
  end else begin : g_acomb
    assign w_a = a;
  end
  if (BREG != 0) begin : g_breg
    logic [17:0] r_b;
    always_ff @(posedge clock or negedge reset)
      if (!reset) r_b <= '0;
      else if (ceb) r_b <= b;
    assign w_b = r_b;
  end else begin : g_bcomb
    assign w_b = b;
  end
  if (CREG != 0) begin : g_creg
    logic [47:0] r_c;
    always_ff @(posedge clock or negedge reset)
      if (!reset) r_c <= '0;
      else if (cec) r_c <= c;
    assign w_c = r_c;
  end else begin : g_ccomb
    assign w_c = c;
  end
  assign w_ab = {w_a, w_b};
  assign w_ma = {{21{w_a[26]}}, w_a[26:0]};
  assign w_mb = {{30{w_b[17]}}, w_b};
  assign w_m  = MUL_ON ? w_ma * w_mb : '0;
  assign w_x = opmode[1:0] == 2'b01 ? w_m : opmode[1:0] == 2'b10 ? w_pfb : opmode[1:0] == 2'b11 ? w_ab : '0;
  assign w_y = opmode[3:2] == 2'b10 ? '1 : opmode[3:2] == 2'b11 ? w_c : '0;
  assign w_z = opmode[6:4] == 3'b010 ? w_pfb : opmode[6:4] == 3'b011 ? w_c : '0;
  assign w_w = opmode[8:7] == 2'b01 ? w_pfb : opmode[8:7] == 2'b11 ? w_c : '0;
  assign w_arith = alumode[3:2] == 2'b00;
  assign w_y2 = opmode[3:2] == 2'b10;
  // Each lane sums with 3 guard bits so no carry or borrow leaks into its neighbour.
  for (genvar i = 0; i < NL; i++) begin : g_lane
    logic [LW+2:0] w_zl, w_s, w_t, w_d, w_n;
    assign w_zl = {3'b000, w_z[i*LW +: LW]};
    assign w_s  = {3'b000, w_w[i*LW +: LW]} + {3'b000, w_x[i*LW +: LW]} + {3'b000, w_y[i*LW +: LW]}
                + {{(LW+2){1'b0}}, (i == 0) && carryin};
    assign w_t  = w_zl + w_s;
    assign w_d  = w_zl - w_s;
    assign w_n  = w_s - w_zl - {{(LW+2){1'b0}}, 1'b1};
    assign w_ar[i*LW +: LW] = alumode == 4'b0000 ? w_t[LW-1:0] : alumode == 4'b0010 ? ~w_t[LW-1:0]
                            : alumode == 4'b0011 ? w_d[LW-1:0] : w_n[LW-1:0];
    assign w_lc[i] = alumode == 4'b0011 ? w_zl >= w_s : alumode == 4'b0001 ? w_s > w_zl : |w_t[LW+2:LW];
  end
  always_comb begin
    w_co = '0;
    for (int i = 0; i < NL; i++) w_co[(i + 1) * (4 / NL) - 1] = w_lc[i] & w_arith;
  end
  always_comb begin
    case (alumode)
      4'b0100, 4'b0111: w_lg = w_y2 ? ~(w_x ^ w_z) : w_x ^ w_z;
      4'b0101, 4'b0110: w_lg = w_y2 ? w_x ^ w_z : ~(w_x ^ w_z);
      4'b1100:          w_lg = w_y2 ? w_x | w_z : w_x & w_z;
      4'b1101:          w_lg = w_y2 ? w_x | ~w_z : w_x & ~w_z;
      4'b1110:          w_lg = w_y2 ? ~(w_x | w_z) : ~(w_x & w_z);
      4'b1111:          w_lg = w_y2 ? ~w_x & w_z : ~w_x | w_z;
      default:          w_lg = '0;
    endcase
  end
  assign w_alu = w_arith ? w_ar : w_lg;
  if (PREG != 0) begin : g_preg
    logic [47:0] r_p;
    logic [3:0]  r_co;
    always_ff @(posedge clock or negedge reset)
      if (!reset) begin
        r_p  <= '0;
        r_co <= '0;
      end else if (cep) begin
        r_p  <= w_alu;
        r_co <= w_co;
      end
    assign p = r_p;
    assign carryout = r_co;
    assign w_pfb = r_p;
  end else begin : g_pcomb
    assign p = w_alu;
    assign carryout = w_co;
    assign w_pfb = '0;
  end
endmodule

// File: tb/tb_dsp48e2.sv
// tb_dsp48e2: directed and randomized checks of dsp48e2 in several parameterisations
// against an arithmetic reference model.
module tb_dsp48e2;
  logic        clock = 1'b0, reset = 1'b0, carryin = 1'b0;
  logic [29:0] a = '0;
  logic [17:0] b = '0;
  logic [47:0] c = '0;
  logic [3:0]  alumode = '0;
  logic [8:0]  opmode = '0;
  logic        cea = 1'b1, ceb = 1'b1, cec = 1'b1, cep = 1'b1;
  logic [47:0] p0, p1, p2, p3, p4, ep;
  logic [3:0]  co0, co1, co2, co3, co4, ec;
  int tests = 0, fails = 0;

  always #5 clock = ~clock;

  dsp48e2 #(.USE_SIMD("FOUR12"), .AREG(0), .BREG(0), .CREG(0), .PREG(0)) u0 (
    .clock(clock), .reset(reset), .a(a), .b(b), .c(c), .carryin(carryin), .alumode(alumode),
    .opmode(opmode), .cea(cea), .ceb(ceb), .cec(cec), .cep(cep), .p(p0), .carryout(co0));
  dsp48e2 u1 (
    .clock(clock), .reset(reset), .a(a), .b(b), .c(c), .carryin(carryin), .alumode(alumode),
    .opmode(opmode), .cea(cea), .ceb(ceb), .cec(cec), .cep(cep), .p(p1), .carryout(co1));
  dsp48e2 #(.AREG(0), .BREG(0), .CREG(0), .PREG(1)) u2 (
    .clock(clock), .reset(reset), .a(a), .b(b), .c(c), .carryin(carryin), .alumode(alumode),
    .opmode(opmode), .cea(cea), .ceb(ceb), .cec(cec), .cep(cep), .p(p2), .carryout(co2));
  dsp48e2 #(.AREG(0), .BREG(0), .CREG(0), .PREG(0)) u3 (
    .clock(clock), .reset(reset), .a(a), .b(b), .c(c), .carryin(carryin), .alumode(alumode),
    .opmode(opmode), .cea(cea), .ceb(ceb), .cec(cec), .cep(cep), .p(p3), .carryout(co3));
  dsp48e2 #(.USE_SIMD("TWO24"), .AREG(0), .BREG(0), .CREG(0), .PREG(0)) u4 (
    .clock(clock), .reset(reset), .a(a), .b(b), .c(c), .carryin(carryin), .alumode(alumode),
    .opmode(opmode), .cea(cea), .ceb(ceb), .cec(cec), .cep(cep), .p(p4), .carryout(co4));

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // Reference for a slice with no P register, so every P selection reads as 0.
  function automatic void model(input int nl, input logic [29:0] ma, input logic [17:0] mb,
                                input logic [47:0] mc, input logic [8:0] op, input logic [3:0] alu,
                                input logic ci, output logic [47:0] rp, output logic [3:0] rc);
    int lw;
    longint mask, zl, s, r;
    logic cy;
    logic [47:0] m, x, y, z, w;
    lw = 48 / nl;
    mask = (longint'(1) << lw) - 1;
    m = (nl == 1) ? 48'(longint'($signed(ma[26:0])) * longint'($signed(mb))) : 48'h0;
    x = op[1:0] == 2'd1 ? m : op[1:0] == 2'd3 ? {ma, mb} : 48'h0;
    y = op[3:2] == 2'd2 ? {48{1'b1}} : op[3:2] == 2'd3 ? mc : 48'h0;
    z = op[6:4] == 3'd3 ? mc : 48'h0;
    w = op[8:7] == 2'd3 ? mc : 48'h0;
    rp = '0;
    rc = '0;
    if (alu <= 4'd3) begin
      for (int l = 0; l < nl; l++) begin
        zl = longint'(z >> (l * lw)) & mask;
        s = (longint'(w >> (l * lw)) & mask) + (longint'(x >> (l * lw)) & mask)
          + (longint'(y >> (l * lw)) & mask) + ((l == 0 && ci) ? 64'sd1 : 64'sd0);
        case (alu)
          4'd0:    begin r = zl + s;      cy = (zl + s) > mask; end
          4'd2:    begin r = ~(zl + s);   cy = (zl + s) > mask; end
          4'd3:    begin r = zl - s;      cy = zl >= s;         end
          default: begin r = s - zl - 1;  cy = s > zl;          end
        endcase
        rp = rp | (48'(r & mask) << (l * lw));
        rc[(l + 1) * (4 / nl) - 1] = cy;
      end
    end else begin
      case (alu)
        4'd4, 4'd7: rp = (op[3:2] == 2'd2) ? ~(x ^ z) : x ^ z;
        4'd5, 4'd6: rp = (op[3:2] == 2'd2) ? x ^ z : ~(x ^ z);
        4'd12:      rp = (op[3:2] == 2'd2) ? x | z : x & z;
        4'd13:      rp = (op[3:2] == 2'd2) ? x | ~z : x & ~z;
        4'd14:      rp = (op[3:2] == 2'd2) ? ~(x | z) : ~(x & z);
        4'd15:      rp = (op[3:2] == 2'd2) ? ~x & z : ~x | z;
        default:    rp = '0;
      endcase
    end
  endfunction

  initial begin
    #12;
    reset = 1'b1;
    {a, b} = 48'd1;
    opmode = 9'b000100011;
    alumode = 4'b0000;
    tick;
    tick;
    reset = 1'b0;
    #1;
    chk("reset_async_p", p2, 48'h0);
    chk("reset_async_co", 48'(co2), 48'h0);
    chk("reset_async_p_default", p1, 48'h0);
    tick;
    chk("reset_held_p", p2, 48'h0);
    cep = 1'b0;
    reset = 1'b1;
    tick;
    chk("post_reset_no_cep", p2, 48'h0);
    cep = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick;
      chk($sformatf("acc_%0d", k), p2, 48'(k));
    end
    chk("acc_co", 48'(co2), 48'h0);
    cep = 1'b0;
    tick;
    chk("acc_hold_cep0", p2, 48'd3);
    reset = 1'b0;
    #1;
    chk("acc_mid_reset", p2, 48'h0);
    reset = 1'b1;
    cep = 1'b1;
    tick;
    chk("acc_restart", p2, 48'd1);
    a = 30'd3;
    b = 18'h3FFFE;
    c = '0;
    opmode = 9'b000000101;
    alumode = 4'b0000;
    tick;
    tick;
    chk("mult_neg", p1, 48'hFFFFFFFFFFFA);
    chk("mult_co", 48'(co1), 48'h0);
    cea = 1'b0;
    a = 30'd5;
    tick;
    tick;
    chk("mult_cea_hold", p1, 48'hFFFFFFFFFFFA);
    cea = 1'b1;
    tick;
    tick;
    chk("mult_cea_load", p1, 48'hFFFFFFFFFFF6);
    {a, b} = 48'hABCDEF123456;
    c = 48'hFFF0F000FF00;
    opmode = 9'b000110011;
    alumode = 4'b1100;
    #1;
    chk("four12_and", p0, 48'hABC0E0003400);
    chk("four12_and_co", 48'(co0), 48'h0);
    {a, b} = 48'h000000000FFF;
    c = 48'h000000000001;
    alumode = 4'b0000;
    #1;
    chk("four12_wrap", p0, 48'h0);
    chk("four12_wrap_co", 48'(co0), 48'h1);
    {a, b} = 48'd3;
    c = 48'd10;
    alumode = 4'b0011;
    #1;
    chk("sub_one48", p3, 48'd7);
    chk("sub_one48_co", 48'(co3), 48'h8);
    for (int i = 0; i < 300; i++) begin
      a = 30'($urandom());
      b = 18'($urandom());
      c = {16'($urandom()), $urandom()};
      opmode = 9'($urandom());
      alumode = 4'($urandom());
      carryin = 1'($urandom());
      #1;
      model(4, a, b, c, opmode, alumode, carryin, ep, ec);
      chk($sformatf("rnd%0d_four12_p", i), p0, ep);
      chk($sformatf("rnd%0d_four12_co", i), 48'(co0), 48'(ec));
      model(1, a, b, c, opmode, alumode, carryin, ep, ec);
      chk($sformatf("rnd%0d_one48_p", i), p3, ep);
      chk($sformatf("rnd%0d_one48_co", i), 48'(co3), 48'(ec));
      model(2, a, b, c, opmode, alumode, carryin, ep, ec);
      chk($sformatf("rnd%0d_two24_p", i), p4, ep);
      chk($sformatf("rnd%0d_two24_co", i), 48'(co4), 48'(ec));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
